// File: rtl/fade_pack.sv
// Shared types and constants for the fade-apply block.
package fade_pack;

  localparam int unsigned N_CHAN = 32;
  localparam int unsigned CHAN_W = 5;
  localparam int unsigned LAT    = 4;
  localparam int unsigned SHIFT  = 14;

  typedef logic [CHAN_W-1:0] chan_t;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

endpackage

// File: rtl/fade_cmult.sv
// Three-stage complex multiply, round and saturate datapath with a common enable.
// Optional clamp: define FADE_APPLY_SAT_EN to clamp results and report saturation.
module fade_cmult
  import fade_pack::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    en_i,
  input  logic    valid_i,
  input  chan_t   chan_i,
  input  cplx16_t samp_i,
  input  cplx16_t coef_i,
  output logic    valid_o,
  output chan_t   chan_o,
  output cplx16_t samp_o,
  output logic    sat_o
);

  localparam logic signed [32:0] RoundC = 33'sd1 <<< (SHIFT - 1);

  logic               v2_q, v3_q, v4_q;
  chan_t              c2_q, c3_q, c4_q;
  logic signed [31:0] ac_d, bd_d, ad_d, bc_d;
  logic signed [31:0] ac_q, bd_q, ad_q, bc_q;
  logic signed [32:0] re3_d, im3_d, re3_q, im3_q;
  logic signed [32:0] re_sh, im_sh;
  cplx16_t            out_d, out_q;

  // Stage 2 operands: four signed 16x16 products (each fits in 32 bits).
  always_comb begin
    ac_d = 32'($signed(samp_i.re)) * 32'($signed(coef_i.re));
    bd_d = 32'($signed(samp_i.im)) * 32'($signed(coef_i.im));
    ad_d = 32'($signed(samp_i.re)) * 32'($signed(coef_i.im));
    bc_d = 32'($signed(samp_i.im)) * 32'($signed(coef_i.re));
  end

  // Stage 3 operands: combine products and add the half-LSB rounding constant.
  always_comb begin
    re3_d = 33'(ac_q) - 33'(bd_q) + RoundC;
    im3_d = 33'(ad_q) + 33'(bc_q) + RoundC;
  end

  // Stage 4 operands: arithmetic scale back to unity gain.
  always_comb begin
    re_sh = re3_q >>> SHIFT;
    im_sh = im3_q >>> SHIFT;
  end

`ifdef FADE_APPLY_SAT_EN
  logic clip;
  logic sat_q;

  // Clamp each component to the signed 16-bit range and flag any clamp.
  always_comb begin
    out_d = '{re: re_sh[15:0], im: im_sh[15:0]};
    clip  = 1'b0;
    if (re_sh > 33'sd32767) begin
      out_d.re = 16'sh7fff;
      clip     = 1'b1;
    end else if (re_sh < -33'sd32768) begin
      out_d.re = 16'sh8000;
      clip     = 1'b1;
    end
    if (im_sh > 33'sd32767) begin
      out_d.im = 16'sh7fff;
      clip     = 1'b1;
    end else if (im_sh < -33'sd32768) begin
      out_d.im = 16'sh8000;
      clip     = 1'b1;
    end
  end

  // Sticky saturation flag, only counting real samples moving into the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (en_i && v3_q && clip) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_o = sat_q;
`else
  // Two's-complement wrap: keep only the low 16 bits.
  always_comb begin
    out_d = '{re: re_sh[15:0], im: im_sh[15:0]};
  end

  logic unused_sh;
  assign unused_sh = ^{re_sh[32:16], im_sh[32:16]};
  assign sat_o     = 1'b0;
`endif

  // Pipeline registers; everything holds when the enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      c2_q  <= '0;
      c3_q  <= '0;
      c4_q  <= '0;
      ac_q  <= '0;
      bd_q  <= '0;
      ad_q  <= '0;
      bc_q  <= '0;
      re3_q <= '0;
      im3_q <= '0;
      out_q <= '0;
    end else if (en_i) begin
      v2_q  <= valid_i;
      c2_q  <= chan_i;
      ac_q  <= ac_d;
      bd_q  <= bd_d;
      ad_q  <= ad_d;
      bc_q  <= bc_d;
      v3_q  <= v2_q;
      c3_q  <= c2_q;
      re3_q <= re3_d;
      im3_q <= im3_d;
      v4_q  <= v3_q;
      c4_q  <= c3_q;
      out_q <= out_d;
    end
  end

  assign valid_o = v4_q;
  assign chan_o  = c4_q;
  assign samp_o  = out_q;

endmodule

// File: rtl/fade_apply.sv
// Applies double-buffered per-channel fade coefficients to a complex sample stream.
// Optional clamp: define FADE_APPLY_SAT_EN to saturate outputs and drive sat_flag.
module fade_apply
  import fade_pack::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        coef_dv,
  input  logic [4:0]  coef_chan,
  input  logic [15:0] coef_imag,
  input  logic [15:0] coef_real,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_chan,
  input  logic [15:0] s_imag,
  input  logic [15:0] s_real,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [4:0]  m_chan,
  output logic [15:0] m_imag,
  output logic [15:0] m_real,
  output logic        coef_ok,
  output logic        coef_err,
  output logic        sat_flag
);

  logic              bank_sel_q;
  logic [N_CHAN-1:0] mask_q, mask_new;
  logic              coef_ok_q, coef_err_q;
  cplx16_t           bank0_q [N_CHAN];
  cplx16_t           bank1_q [N_CHAN];
  cplx16_t           coef_wr, coef_rd;

  logic              en;
  logic              s1_valid_q;
  chan_t             s1_chan_q;
  cplx16_t           s1_samp_q, s1_coef_q;
  logic              out_valid;
  chan_t             out_chan;
  cplx16_t           out_samp;
  logic              out_sat;

  assign en      = !out_valid || m_ready;
  assign s_ready = en;
  assign coef_wr = '{re: coef_real, im: coef_imag};

  // Mask as it will look once the current write lands.
  always_comb begin
    mask_new            = mask_q;
    mask_new[coef_chan] = 1'b1;
  end

  // Set tracking: channel 0 closes a set and either swaps banks or flags an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel_q <= 1'b0;
      mask_q     <= '0;
      coef_ok_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else if (coef_dv) begin
      if (coef_chan == '0) begin
        mask_q <= '0;
        if (&mask_new) begin
          bank_sel_q <= ~bank_sel_q;
          coef_ok_q  <= 1'b1;
        end else begin
          coef_err_q <= 1'b1;
        end
      end else begin
        mask_q <= mask_new;
      end
    end
  end

  // Coefficient banks are plain storage; writes always target the inactive bank.
  always_ff @(posedge clk) begin
    if (coef_dv) begin
      if (bank_sel_q) begin
        bank0_q[coef_chan] <= coef_wr;
      end else begin
        bank1_q[coef_chan] <= coef_wr;
      end
    end
  end

  // Active-bank read; zero gain until the first full set has been swapped in.
  always_comb begin
    coef_rd = '0;
    if (coef_ok_q) begin
      coef_rd = bank_sel_q ? bank1_q[s_chan] : bank0_q[s_chan];
    end
  end

  // Stage 1: capture sample with the coefficient seen on its accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_chan_q  <= '0;
      s1_samp_q  <= '0;
      s1_coef_q  <= '0;
    end else if (en) begin
      s1_valid_q <= s_valid;
      s1_chan_q  <= s_chan;
      s1_samp_q  <= '{re: s_real, im: s_imag};
      s1_coef_q  <= coef_rd;
    end
  end

  fade_cmult u_cmult (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en),
    .valid_i (s1_valid_q),
    .chan_i  (s1_chan_q),
    .samp_i  (s1_samp_q),
    .coef_i  (s1_coef_q),
    .valid_o (out_valid),
    .chan_o  (out_chan),
    .samp_o  (out_samp),
    .sat_o   (out_sat)
  );

  assign m_valid  = out_valid;
  assign m_chan   = out_chan;
  assign m_real   = out_samp.re;
  assign m_imag   = out_samp.im;
  assign coef_ok  = coef_ok_q;
  assign coef_err = coef_err_q;
  assign sat_flag = out_sat;

endmodule

// File: tb/tb_fade_apply.sv
// Directed self-checking bench for fade_apply.
module tb_fade_apply;
  import fade_pack::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               coef_dv;
  logic [4:0]         coef_chan;
  logic signed [15:0] coef_imag, coef_real;
  logic               s_valid, s_ready;
  logic [4:0]         s_chan;
  logic signed [15:0] s_imag, s_real;
  logic               m_valid, m_ready;
  logic [4:0]         m_chan;
  logic signed [15:0] m_imag, m_real;
  logic               coef_ok, coef_err, sat_flag;

  int n_checks = 0;
  int n_errors = 0;

  int bp_got, bp_tmo, hits, lat;
  logic [4:0]         oc;
  logic signed [15:0] ore, oim;

  always #5 clk = ~clk;

  fade_apply dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .coef_dv   (coef_dv),
    .coef_chan (coef_chan),
    .coef_imag (coef_imag),
    .coef_real (coef_real),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_chan    (s_chan),
    .s_imag    (s_imag),
    .s_real    (s_real),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_chan    (m_chan),
    .m_imag    (m_imag),
    .m_real    (m_real),
    .coef_ok   (coef_ok),
    .coef_err  (coef_err),
    .sat_flag  (sat_flag)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int ch, input logic signed [15:0] re,
                            input logic signed [15:0] im);
    coef_dv   = 1'b1;
    coef_chan = 5'(ch);
    coef_real = re;
    coef_imag = im;
    tick();
    coef_dv = 1'b0;
    tick();
  endtask

  // Full set 31..0 (minus skip), default value everywhere except sp_ch.
  task automatic load_set(input int skip, input int sp_ch,
                          input logic signed [15:0] sp_re, input logic signed [15:0] sp_im,
                          input logic signed [15:0] d_re, input logic signed [15:0] d_im);
    for (int ch = 31; ch >= 0; ch--) begin
      if (ch != skip) begin
        if (ch == sp_ch) write_coef(ch, sp_re, sp_im);
        else write_coef(ch, d_re, d_im);
      end
    end
    tick();
    tick();
  endtask

  // Single sample with m_ready high; reports output and cycles from accept to m_valid.
  task automatic apply_one(input int ch, input logic signed [15:0] re,
                           input logic signed [15:0] im, output logic [4:0] o_ch,
                           output logic signed [15:0] o_re, output logic signed [15:0] o_im,
                           output int o_lat);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_chan  = 5'(ch);
    s_real  = re;
    s_imag  = im;
    @(negedge clk);
    check_eq("accept_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    o_lat = 0;
    o_ch  = '0;
    o_re  = '0;
    o_im  = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_valid) begin
        o_lat = k;
        o_ch  = m_chan;
        o_re  = m_real;
        o_im  = m_imag;
        break;
      end
    end
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    coef_dv   = 1'b0;
    coef_chan = '0;
    coef_real = '0;
    coef_imag = '0;
    s_valid   = 1'b0;
    s_chan    = '0;
    s_real    = '0;
    s_imag    = '0;
    m_ready   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_coef_ok", coef_ok, 0);
    check_eq("rst_coef_err", coef_err, 0);
    check_eq("rst_sat", sat_flag, 0);
    check_eq("rst_m_real", m_real, 0);
    check_eq("rst_m_chan", m_chan, 0);

    // Unity set, then pass-through on chan 3.
    load_set(-1, -1, 16'sd0, 16'sd0, 16'sd16384, 16'sd0);
    check_eq("set1_coef_ok", coef_ok, 1);
    check_eq("set1_coef_err", coef_err, 0);
    apply_one(3, 16'sd1000, -16'sd500, oc, ore, oim, lat);
    check_eq("unity_chan", oc, 3);
    check_eq("unity_re", ore, 1000);
    check_eq("unity_im", oim, -500);
    check_eq("unity_lat", lat, LAT);

    // Chan 7 multiplies by j.
    load_set(-1, 7, 16'sd0, 16'sd16384, 16'sd16384, 16'sd0);
    apply_one(7, 16'sd1000, -16'sd500, oc, ore, oim, lat);
    check_eq("rot_chan", oc, 7);
    check_eq("rot_re", ore, 500);
    check_eq("rot_im", oim, 1000);
    check_eq("rot_lat", lat, LAT);

    // Incomplete set (chan 12 missing): error, no swap.
    load_set(12, -1, 16'sd0, 16'sd0, 16'sd8192, 16'sd8192);
    check_eq("err_coef_err", coef_err, 1);
    check_eq("err_coef_ok", coef_ok, 1);
    apply_one(5, 16'sd1000, -16'sd500, oc, ore, oim, lat);
    check_eq("err_old_re", ore, 1000);
    check_eq("err_old_im", oim, -500);

    // Backpressure: six back-to-back samples, output held then released.
    bp_got  = 0;
    bp_tmo  = 0;
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          s_valid = 1'b1;
          s_chan  = 5'(16 + i);
          s_real  = 16'(100 * (i + 1));
          s_imag  = 16'(-7 * (i + 1));
          begin : wait_rdy
            for (int t = 0; t < 60; t++) begin
              @(negedge clk);
              if (s_ready) disable wait_rdy;
              if (t == 59) bp_tmo++;
            end
          end
          tick();
        end
        s_valid = 1'b0;
      end
      begin
        repeat (8) tick();
        check_eq("bp_m_valid_held", m_valid, 1);
        check_eq("bp_s_ready_low", s_ready, 0);
        m_ready = 1'b1;
        for (int t = 0; t < 60 && bp_got < 6; t++) begin
          @(negedge clk);
          if (m_valid && m_ready) begin
            check_eq("bp_chan", m_chan, 16 + bp_got);
            check_eq("bp_re", m_real, 100 * (bp_got + 1));
            check_eq("bp_im", m_imag, -7 * (bp_got + 1));
            bp_got++;
          end
        end
      end
    join
    check_eq("bp_count", bp_got, 6);
    check_eq("bp_timeouts", bp_tmo, 0);
    repeat (3) tick();
    check_eq("bp_drained", m_valid, 0);

    // Extreme operands: wrap or clamp depending on build.
    load_set(-1, 9, -16'sd32768, -16'sd32768, 16'sd16384, 16'sd0);
    apply_one(9, -16'sd32768, -16'sd32768, oc, ore, oim, lat);
    check_eq("sat_re", ore, 0);
`ifdef FADE_APPLY_SAT_EN
    check_eq("sat_im", oim, 32767);
    check_eq("sat_flag", sat_flag, 1);
`else
    check_eq("sat_im", oim, 0);
    check_eq("sat_flag", sat_flag, 0);
`endif

    // Reset with three samples in flight.
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_chan = 5'(i);
      s_real = 16'sd1000;
      s_imag = 16'sd1000;
      tick();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_m_valid", m_valid, 0);
    check_eq("mid_rst_coef_ok", coef_ok, 0);
    tick();
    tick();
    reset_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid) hits++;
    end
    check_eq("mid_rst_flushed", hits, 0);
    check_eq("mid_rst_coef_err", coef_err, 0);
    check_eq("mid_rst_sat", sat_flag, 0);
    tick();
    apply_one(4, 16'sd1000, -16'sd500, oc, ore, oim, lat);
    check_eq("post_rst_chan", oc, 4);
    check_eq("post_rst_re", ore, 0);
    check_eq("post_rst_im", oim, 0);
    check_eq("post_rst_lat", lat, LAT);
    check_eq("post_rst_coef_ok", coef_ok, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
